// File: rtl/addr4u_seq_pkg.sv
// -----------------------------------------------------------------------------
// addr4u_seq_pkg
// Shared definitions for the serial nibble-adder sequencer:
//   - state_e     : sequencer states (CALC_B is only reachable when
//                   ADDR4U_SEQ_REDUNDANT_EN is defined)
//   - NIBBLE_W    : width of the nibble adder datapath
//   - nib_idx_w() : width of the nibble index register for a given WIDTH
// -----------------------------------------------------------------------------
package addr4u_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_A = 2'd1,
        CALC_B = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Index must count 0..WIDTH/4-1; a single-nibble operand still gets a
    // one-bit index so the register never collapses to zero width.
    function automatic int nib_idx_w(input int width);
        int nib;
        nib = width / NIBBLE_W;
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/addr4u_nibble_add.sv
// -----------------------------------------------------------------------------
// addr4u_nibble_add
// Combinational 4-bit adder with carry-in. The 5-bit result is {cout, sum}.
// Ports:
//   a_i   [3:0]  nibble of addend A
//   b_i   [3:0]  nibble of addend B
//   cin_i        carry-in
//   res_o [4:0]  {carry-out, sum nibble}
// -----------------------------------------------------------------------------
module addr4u_nibble_add
    import addr4u_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W:0]   res_o
);

    assign res_o = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, cin_i};

endmodule

// File: rtl/addr4u_seq_ctrl.sv
// -----------------------------------------------------------------------------
// addr4u_seq_ctrl
// Performs a WIDTH-bit unsigned add by stepping one shared nibble adder
// through WIDTH/4 cycles, least significant nibble first, with the carry
// held in a register between nibbles.
//
// Build option: ADDR4U_SEQ_REDUNDANT_EN
//   defined   : every nibble is computed twice (CALC_A, CALC_B) and compared;
//               a mismatch retries the nibble up to MAX_RETRY times, after
//               which the CALC_B result is kept and out_err is raised.
//   undefined : single pass per nibble, out_err tied low, MAX_RETRY unused.
//
// Parameters:
//   WIDTH      operand width, multiple of 4 and >= 4
//   MAX_RETRY  extra compute pairs allowed per nibble on mismatch
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin    operands and carry-in to nibble 0
//   out_valid / out_ready result handshake (valid only in DONE)
//   out_sum, out_cout     sum and carry-out of the top nibble
//   out_err               unrecoverable nibble mismatch in this transaction
//   fi_mask               XORed onto the {cout,sum} nibble-adder result
// -----------------------------------------------------------------------------
module addr4u_seq_ctrl
    import addr4u_seq_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_RETRY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_err,
    input  logic [4:0]       fi_mask
);

    localparam int                NIB      = WIDTH / NIBBLE_W;
    localparam int                IDX_W    = nib_idx_w(WIDTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIB - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 carry_q, carry_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [NIBBLE_W-1:0]  nib_a, nib_b;
    logic [NIBBLE_W:0]    raw_res, res;
    logic                 commit;

`ifdef ADDR4U_SEQ_REDUNDANT_EN
    localparam int               RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic [NIBBLE_W:0]    chk_q, chk_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 err_q, err_d;
`else
    // Keeps MAX_RETRY referenced in the single-pass build.
    localparam int unused_max_retry = MAX_RETRY;
`endif

    // Operand nibbles for the current index feed the single adder instance.
    assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    addr4u_nibble_add u_nibble_add (
        .a_i   (nib_a),
        .b_i   (nib_b),
        .cin_i (carry_q),
        .res_o (raw_res)
    );

    // Fault-injection hook sits on the adder output, ahead of any compare.
    assign res = raw_res ^ fi_mask;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
`ifdef ADDR4U_SEQ_REDUNDANT_EN
    assign out_err   = err_q;
`else
    assign out_err   = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        commit  = 1'b0;
`ifdef ADDR4U_SEQ_REDUNDANT_EN
        chk_d   = chk_q;
        retry_d = retry_q;
        err_d   = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
`ifdef ADDR4U_SEQ_REDUNDANT_EN
                    retry_d = '0;
                    err_d   = 1'b0;
`endif
                    state_d = CALC_A;
                end
            end
            CALC_A: begin
`ifdef ADDR4U_SEQ_REDUNDANT_EN
                chk_d   = res;
                state_d = CALC_B;
`else
                commit  = 1'b1;
`endif
            end
            CALC_B: begin
`ifdef ADDR4U_SEQ_REDUNDANT_EN
                if (res == chk_q) begin
                    commit = 1'b1;
                end else if (retry_q != RETRY_MAX) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = CALC_A;
                end else begin
                    // Out of retries: keep the second result and flag it.
                    commit = 1'b1;
                    err_d  = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Commit the nibble and advance; shared by the single-pass and the
        // redundant paths so both write sum/carry identically.
        if (commit) begin
            sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = res[NIBBLE_W-1:0];
            carry_d = res[NIBBLE_W];
`ifdef ADDR4U_SEQ_REDUNDANT_EN
            retry_d = '0;
`endif
            if (idx_q == LAST_IDX) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = CALC_A;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef ADDR4U_SEQ_REDUNDANT_EN
            chk_q   <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
`ifdef ADDR4U_SEQ_REDUNDANT_EN
            chk_q   <= chk_d;
            retry_q <= retry_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_addr4u_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_addr4u_seq_ctrl
// Self-checking bench for addr4u_seq_ctrl (WIDTH=16). Expected results come
// from a nibble-level arithmetic model; a compare process checks the result
// port against the expectation queue on every cycle out_valid is high.
// Works in both builds; fault scenarios adapt to ADDR4U_SEQ_REDUNDANT_EN.
// -----------------------------------------------------------------------------
module tb_addr4u_seq_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;
`ifdef ADDR4U_SEQ_REDUNDANT_EN
    localparam int LAT = 2 * NIB;
`else
    localparam int LAT = NIB;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_err;
    logic [4:0]   fi_mask = '0;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    addr4u_seq_ctrl #(.WIDTH(W), .MAX_RETRY(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_err   (out_err),
        .fi_mask   (fi_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single-pass reference: nibble-serial add, optional XOR of mask onto
    // nibble fnib's {cout,sum}; fnib < 0 means no fault.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic [4:0] mask, input int fnib);
        exp_t r;
        int   c;
        int   v;
        c = cin;
        r = '0;
        for (int k = 0; k < NIB; k++) begin
            v = int'((a >> (4*k)) & 16'hF) + int'((b >> (4*k)) & 16'hF) + c;
            if (k == fnib) v = v ^ int'(mask);
            r.sum = r.sum | (W'(v % 16) << (4*k));
            c = v / 16;
        end
        r.cout = c[0];
        return r;
    endfunction

    // Compare process: results must match the head expectation whenever valid.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("out_sum",  32'(out_sum),  32'(exp_q[0].sum));
                check("out_cout", 32'(out_cout), 32'(exp_q[0].cout));
                check("out_err",  32'(out_err),  32'(exp_q[0].err));
                check("in_ready_in_done", 32'(in_ready), 32'd0);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
    endtask

    // Issue one transaction; fi_mask is driven with mask on each cycle whose
    // bit is set in fcyc (cycle 0 = first cycle after the accept edge).
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input int stall, input logic [4:0] mask, input logic [31:0] fcyc,
                           input exp_t exp, input int exp_lat);
        int cyc;
        wait_ready();
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(exp);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            fi_mask   = (cyc < 32 && fcyc[cyc]) ? mask : 5'd0;
            // Junk on the input port and out_ready must be ignored while busy.
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        fi_mask = '0; in_valid = 1'b0; out_ready = 1'b0;
        check("latency", 32'(cyc), 32'(exp_lat));
        if (!out_valid) begin
            exp_q.delete();
            return;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        check("out_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum"},   32'(out_sum),   32'd0);
        check({tag, "_out_cout"},  32'(out_cout),  32'd0);
        check({tag, "_out_err"},   32'(out_err),   32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        logic         c;
        logic [4:0]   m;
        int           fn;
        exp_t         e;

        // Reset state.
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Pin the model against hand-computed values.
        check("model_ffff_1",   32'(model(16'hFFFF, 16'h0001, 1'b0, 5'd0, -1)), 32'({16'h0000, 1'b1, 1'b0}));
        check("model_1234_4321", 32'(model(16'h1234, 16'h4321, 1'b1, 5'd0, -1)), 32'({16'h5556, 1'b0, 1'b0}));
        check("model_fault_nib1", 32'(model(16'h00F0, 16'h0010, 1'b0, 5'b00001, 1)), 32'({16'h0110, 1'b0, 1'b0}));

        // Directed cases.
        run_txn(16'hFFFF, 16'h0001, 1'b0, 0, 5'd0, 32'd0, '{16'h0000, 1'b1, 1'b0}, LAT);
        run_txn(16'h1234, 16'h4321, 1'b1, 5, 5'd0, 32'd0, '{16'h5556, 1'b0, 1'b0}, LAT);
        run_txn(16'h8000, 16'h8000, 1'b0, 0, 5'd0, 32'd0, '{16'h0000, 1'b1, 1'b0}, LAT);

`ifdef ADDR4U_SEQ_REDUNDANT_EN
        // Transient fault in nibble 1 CALC_A: one retry recovers it.
        run_txn(16'h00F0, 16'h0010, 1'b0, 0, 5'b00001, 32'h0000_0004, '{16'h0100, 1'b0, 1'b0}, LAT + 2);
        // Persistent fault on every CALC_B of nibble 0: retries exhausted.
        run_txn(16'h0003, 16'h0001, 1'b0, 1, 5'b00010, 32'h0000_000A, '{16'h0006, 1'b0, 1'b1}, LAT + 2);
`else
        // Undetected corruption of nibble 1 with carry propagation.
        run_txn(16'h00F0, 16'h0010, 1'b0, 0, 5'b00001, 32'h0000_0002,
                model(16'h00F0, 16'h0010, 1'b0, 5'b00001, 1), LAT);
`endif

        // Reset during nibble 2 aborts the transaction.
        wait_ready();
        in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2 * LAT / NIB) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (3) begin
            @(posedge clk); #1;
            check("midreset_no_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(16'hABCD, 16'h1111, 1'b1, 0, 5'd0, 32'd0, model(16'hABCD, 16'h1111, 1'b1, 5'd0, -1), LAT);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom_range(0, 1));
`ifdef ADDR4U_SEQ_REDUNDANT_EN
            run_txn(a, b, c, int'($urandom_range(0, 3)), 5'd0, 32'd0, model(a, b, c, 5'd0, -1), LAT);
`else
            if ($urandom_range(0, 2) == 0) begin
                fn = int'($urandom_range(0, NIB - 1));
                m  = 5'($urandom_range(1, 31));
            end else begin
                fn = -1;
                m  = 5'd0;
            end
            e = model(a, b, c, m, fn);
            run_txn(a, b, c, int'($urandom_range(0, 3)), m, (fn >= 0) ? (32'd1 << fn) : 32'd0, e, LAT);
`endif
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
